// File: rtl/console_arbiter.sv
// Round-robin arbiter sharing one console sink among NREQ Wishbone-style requesters.
// Define CONSOLE_ARB_LINE_LOCK_EN to keep each requester's output line contiguous.
module console_arbiter #(
   parameter int NREQ         = 2,
   parameter int LOCK_TIMEOUT = 255
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [NREQ-1:0]     i_req_stb,
   input  logic [NREQ*32-1:0]  i_req_data,
   output logic [NREQ-1:0]     o_req_ack,
   output logic [NREQ-1:0]     o_req_stall,
   output logic                o_con_stb,
   output logic [31:0]         o_con_data,
   input  logic                i_con_ack,
   input  logic                i_con_stall,
   output logic [2:0]          o_grant,
   output logic                o_busy
);

   if (NREQ < 2 || NREQ > 8 || LOCK_TIMEOUT < 1) begin : g_bad_params
      $error("console_arbiter: NREQ must be 2..8 and LOCK_TIMEOUT must be >= 1");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

   state_t            state, state_next;
   logic [2:0]        rr_ptr;
   logic [2:0]        win;
   logic [2:0]        next_ptr;
   logic              win_valid;
   logic [NREQ-1:0]   eligible;
   logic [NREQ-1:0]   win_onehot;
   logic [NREQ-1:0]   grant_onehot;
   logic [31:0]       win_data;

`ifdef CONSOLE_ARB_LINE_LOCK_EN
   localparam int            CW           = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT_MAX  = CW'(LOCK_TIMEOUT);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);

   logic              lock;
   logic [2:0]        lock_owner;
   logic [CW-1:0]     idle_cnt;
   logic              owner_stb;
`endif

   // Winner search: the lowest offset from rr_ptr among eligible strobes.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      eligible = i_req_stb;
`ifdef CONSOLE_ARB_LINE_LOCK_EN
      owner_stb = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (3'(i) == lock_owner) owner_stb = i_req_stb[i];
         else if (lock)           eligible[i] = 1'b0;
      end
`endif
      win_valid = 1'b0;
      win       = '0;
      for (int k = 0; k < NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!win_valid && eligible[i] && i == (int'(rr_ptr) + k) % NREQ) begin
               win_valid = 1'b1;
               win       = 3'(i);
            end
         end
      end
      win_data     = '0;
      next_ptr     = '0;
      win_onehot   = '0;
      grant_onehot = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (3'(i) == win) begin
            win_data      = i_req_data[32*i +: 32];
            next_ptr      = 3'((i + 1) % NREQ);
            win_onehot[i] = 1'b1;
         end
         if (3'(i) == o_grant) grant_onehot[i] = 1'b1;
      end
   end

   always_comb begin
      state_next  = state;
      o_req_stall = '1;
      case (state)
         IDLE: begin
            if (i_req_stb == '0)  o_req_stall = '0;
            else if (win_valid)   o_req_stall = ~win_onehot;
            if (win_valid) state_next = ISSUE;
         end
         ISSUE:    if (!i_con_stall) state_next = WAIT_ACK;
         WAIT_ACK: if (i_con_ack)    state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   assign o_busy = (state != IDLE);

   always_ff @(posedge i_clk) begin
      if (i_reset) state <= IDLE;
      else         state <= state_next;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_con_stb  <= 1'b0;
         o_con_data <= '0;
         o_req_ack  <= '0;
         o_grant    <= '0;
         rr_ptr     <= '0;
      end else begin
         o_req_ack <= '0;
         case (state)
            IDLE: begin
               if (win_valid) begin
                  o_con_data <= win_data;
                  o_con_stb  <= 1'b1;
                  o_grant    <= win;
                  rr_ptr     <= next_ptr;
               end
            end
            ISSUE:    if (!i_con_stall) o_con_stb <= 1'b0;
            WAIT_ACK: if (i_con_ack)    o_req_ack <= grant_onehot;
            default:  ;
         endcase
      end
   end

`ifdef CONSOLE_ARB_LINE_LOCK_EN
   // A newline from the owner releases the lock; an absent owner releases it on timeout.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         lock       <= 1'b0;
         lock_owner <= '0;
         idle_cnt   <= '0;
      end else if (state == IDLE) begin
         if (win_valid) begin
            idle_cnt <= '0;
            if (win_data[7:0] == 8'h0A) begin
               lock <= 1'b0;
            end else begin
               lock       <= 1'b1;
               lock_owner <= win;
            end
         end else if (lock && !owner_stb && idle_cnt != TIMEOUT_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
            if (idle_cnt == TIMEOUT_LAST) lock <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_console_arbiter.sv
// Directed self-checking bench for console_arbiter (NREQ=2, LOCK_TIMEOUT=8); expectations
// follow CONSOLE_ARB_LINE_LOCK_EN so the same bench covers both builds.
module tb_console_arbiter;
   logic          i_clk = 1'b0;
   logic          i_reset;
   logic [1:0]    i_req_stb;
   logic [63:0]   i_req_data;
   logic [1:0]    o_req_ack;
   logic [1:0]    o_req_stall;
   logic          o_con_stb;
   logic [31:0]   o_con_data;
   logic          i_con_ack;
   logic          i_con_stall;
   logic [2:0]    o_grant;
   logic          o_busy;

   always #5 i_clk = ~i_clk;

   console_arbiter #(.NREQ(2), .LOCK_TIMEOUT(8)) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_req_stb   (i_req_stb),
      .i_req_data  (i_req_data),
      .o_req_ack   (o_req_ack),
      .o_req_stall (o_req_stall),
      .o_con_stb   (o_con_stb),
      .o_con_data  (o_con_data),
      .i_con_ack   (i_con_ack),
      .i_con_stall (i_con_stall),
      .o_grant     (o_grant),
      .o_busy      (o_busy)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int stall_plan = 0;

   logic [31:0] req_q0[$];
   logic [31:0] req_q1[$];
   logic [31:0] con_log[$];
   int          con_cyc[$];
   int          acc_cyc0[$];
   int          acc_cyc1[$];
   logic [1:0]  ack_val[$];
   int          ack_cyc[$];

   task automatic drive_reqs();
      i_req_stb[0]      = (req_q0.size() != 0);
      i_req_data[31:0]  = (req_q0.size() != 0) ? req_q0[0] : 32'h0;
      i_req_stb[1]      = (req_q1.size() != 0);
      i_req_data[63:32] = (req_q1.size() != 0) ? req_q1[0] : 32'h0;
   endtask

   // One clock: requesters and console react to what was accepted at this edge.
   task automatic step();
      logic       acc_con;
      logic [1:0] acc_req;
      acc_con = o_con_stb && !i_con_stall && !i_reset;
      acc_req = i_reset ? 2'b00 : (i_req_stb & ~o_req_stall);
      if (acc_con) begin con_log.push_back(o_con_data); con_cyc.push_back(cyc); end
      if (acc_req[0]) begin void'(req_q0.pop_front()); acc_cyc0.push_back(cyc); end
      if (acc_req[1]) begin void'(req_q1.pop_front()); acc_cyc1.push_back(cyc); end
      @(posedge i_clk);
      #1;
      cyc++;
      i_con_ack   = acc_con;
      i_con_stall = (o_con_stb && stall_plan > 0);
      if (i_con_stall) stall_plan--;
      drive_reqs();
      if (o_req_ack != 2'b00) begin ack_val.push_back(o_req_ack); ack_cyc.push_back(cyc); end
      #1;
   endtask

   task automatic clear_logs();
      con_log.delete(); con_cyc.delete(); acc_cyc0.delete(); acc_cyc1.delete();
      ack_val.delete(); ack_cyc.delete();
   endtask

   task automatic do_reset();
      req_q0.delete(); req_q1.delete();
      stall_plan  = 0;
      i_con_ack   = 1'b0;
      i_con_stall = 1'b0;
      drive_reqs();
      i_reset = 1'b1;
      step();
      step();
      i_reset = 1'b0;
      cyc = 0;
      clear_logs();
   endtask

   task automatic run_until_bytes(input int n, input int budget);
      int left = budget;
      while (con_log.size() < n && left > 0) begin step(); left--; end
      checks++;
      if (con_log.size() != n) begin
         errors++;
         $display("FAIL byte_count: got %0d bytes, expected %0d within %0d cycles", con_log.size(), n, budget);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (o_con_stb !== 1'b0)    begin errors++; $display("FAIL reset_con_stb: got %b expected 0", o_con_stb); end
      checks++; if (o_con_data !== 32'h0)  begin errors++; $display("FAIL reset_con_data: got %h expected 0", o_con_data); end
      checks++; if (o_req_ack !== 2'b00)   begin errors++; $display("FAIL reset_req_ack: got %b expected 00", o_req_ack); end
      checks++; if (o_grant !== 3'd0)      begin errors++; $display("FAIL reset_grant: got %0d expected 0", o_grant); end
      checks++; if (o_busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
      checks++; if (o_req_stall !== 2'b00) begin errors++; $display("FAIL reset_idle_stall: got %b expected 00", o_req_stall); end
   endtask

   task automatic test_single();
      do_reset();
      req_q0.push_back(32'h0000_0041);
      drive_reqs();
      #1;
      checks++; if (o_req_stall !== 2'b10) begin errors++; $display("FAIL single_stall_T: got %b expected 10", o_req_stall); end
      step();
      checks++; if (o_con_stb !== 1'b1)    begin errors++; $display("FAIL single_stb_T1: got %b expected 1", o_con_stb); end
      checks++; if (o_con_data !== 32'h41) begin errors++; $display("FAIL single_data_T1: got %h expected 00000041", o_con_data); end
      checks++; if (o_busy !== 1'b1)       begin errors++; $display("FAIL single_busy_T1: got %b expected 1", o_busy); end
      checks++; if (o_req_stall !== 2'b11) begin errors++; $display("FAIL single_stall_T1: got %b expected 11", o_req_stall); end
      step();
      checks++; if (o_con_stb !== 1'b0)    begin errors++; $display("FAIL single_stb_T2: got %b expected 0", o_con_stb); end
      checks++; if (o_req_ack !== 2'b00)   begin errors++; $display("FAIL single_ack_T2: got %b expected 00", o_req_ack); end
      step();
      checks++; if (o_req_ack !== 2'b01)   begin errors++; $display("FAIL single_ack_T3: got %b expected 01", o_req_ack); end
      checks++; if (o_busy !== 1'b0)       begin errors++; $display("FAIL single_busy_T3: got %b expected 0", o_busy); end
      step();
      checks++; if (o_req_ack !== 2'b00)   begin errors++; $display("FAIL single_ack_T4: got %b expected 00", o_req_ack); end
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_d[4];
      int          exp_c[4];
      exp_d = '{32'h1111_000A, 32'h3333_000A, 32'h2222_000A, 32'h4444_000A};
      exp_c = '{1, 4, 7, 10};
      do_reset();
      req_q0.push_back(32'h1111_000A); req_q0.push_back(32'h2222_000A);
      req_q1.push_back(32'h3333_000A); req_q1.push_back(32'h4444_000A);
      drive_reqs();
      #1;
      run_until_bytes(4, 40);
      if (con_log.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (con_log[k] !== exp_d[k]) begin
               errors++; $display("FAIL rr_data[%0d]: got %h expected %h", k, con_log[k], exp_d[k]);
            end
            checks++;
            if (con_cyc[k] != exp_c[k]) begin
               errors++; $display("FAIL rr_con_cycle[%0d]: got %0d expected %0d", k, con_cyc[k], exp_c[k]);
            end
         end
      end
      checks++;
      if (acc_cyc0.size() != 2 || acc_cyc1.size() != 2 || acc_cyc0[0] != 0 || acc_cyc1[0] != 3 ||
          acc_cyc0[1] != 6 || acc_cyc1[1] != 9) begin
         errors++; $display("FAIL rr_accept_cycles: got req0 n=%0d req1 n=%0d, expected req0 {0,6} req1 {3,9}",
                            acc_cyc0.size(), acc_cyc1.size());
      end
   endtask

   task automatic test_stall();
      do_reset();
      req_q0.push_back(32'h0000_005A);
      stall_plan = 4;
      drive_reqs();
      #1;
      step();
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if ({o_con_stb, o_con_data} !== {1'b1, 32'h5A} || i_con_stall !== 1'b1) begin
            errors++; $display("FAIL stall_hold_T%0d: got stb=%b data=%h expected stb=1 data=0000005a", k, o_con_stb, o_con_data);
         end
         step();
      end
      checks++; if (o_con_stb !== 1'b1)  begin errors++; $display("FAIL stall_stb_T5: got %b expected 1", o_con_stb); end
      step();
      checks++; if (o_req_ack !== 2'b00) begin errors++; $display("FAIL stall_ack_T6: got %b expected 00", o_req_ack); end
      step();
      checks++; if (o_req_ack !== 2'b01) begin errors++; $display("FAIL stall_ack_T7: got %b expected 01", o_req_ack); end
   endtask

   task automatic test_line_lock();
      logic [7:0] exp_b[4];
`ifdef CONSOLE_ARB_LINE_LOCK_EN
      exp_b = '{8'h41, 8'h42, 8'h0A, 8'h58};
`else
      exp_b = '{8'h41, 8'h58, 8'h42, 8'h0A};
`endif
      do_reset();
      req_q0.push_back(32'h41); req_q0.push_back(32'h42); req_q0.push_back(32'h0A);
      req_q1.push_back(32'h58);
      drive_reqs();
      #1;
      run_until_bytes(4, 60);
      if (con_log.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (con_log[k][7:0] !== exp_b[k]) begin
               errors++; $display("FAIL lock_order[%0d]: got %h expected %h", k, con_log[k][7:0], exp_b[k]);
            end
         end
      end
      repeat (3) step();
   endtask

   task automatic test_lock_timeout();
      int left = 40;
`ifdef CONSOLE_ARB_LINE_LOCK_EN
      int         exp_acc   = 11;
      logic [1:0] exp_stall = 2'b11;
`else
      int         exp_acc   = 3;
      logic [1:0] exp_stall = 2'b01;
`endif
      do_reset();
      req_q0.push_back(32'h41);
      req_q1.push_back(32'h58);
      drive_reqs();
      #1;
      while (acc_cyc1.size() == 0 && left > 0) begin
         if (cyc == 3) begin
            checks++;
            if (o_req_stall !== exp_stall) begin
               errors++; $display("FAIL timeout_stall_at_ack: got %b expected %b", o_req_stall, exp_stall);
            end
         end
         step();
         left--;
      end
      checks++;
      if (acc_cyc1.size() != 1 || acc_cyc1[0] != exp_acc) begin
         errors++; $display("FAIL timeout_req1_accept: got n=%0d cycle=%0d expected cycle %0d",
                            acc_cyc1.size(), (acc_cyc1.size() != 0) ? acc_cyc1[0] : -1, exp_acc);
      end
      checks++;
      if (ack_cyc.size() == 0 || ack_cyc[0] != 3 || ack_val[0] !== 2'b01) begin
         errors++; $display("FAIL timeout_req0_ack: got n=%0d expected ack 01 at cycle 3", ack_cyc.size());
      end
      repeat (3) step();
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_q0.push_back(32'h77);
      drive_reqs();
      #1;
      step();
      step();
      checks++; if (o_busy !== 1'b1)       begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", o_busy); end
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      checks++; if (o_con_stb !== 1'b0)    begin errors++; $display("FAIL midrst_stb: got %b expected 0", o_con_stb); end
      checks++; if (o_req_ack !== 2'b00)   begin errors++; $display("FAIL midrst_ack: got %b expected 00", o_req_ack); end
      checks++; if (o_busy !== 1'b0)       begin errors++; $display("FAIL midrst_busy: got %b expected 0", o_busy); end
      step();
      checks++;
      if (o_req_ack !== 2'b00 || ack_val.size() != 0) begin
         errors++; $display("FAIL midrst_late_ack: got ack=%b count=%0d expected none", o_req_ack, ack_val.size());
      end
      req_q0.push_back(32'h66);
      req_q1.push_back(32'h99);
      drive_reqs();
      #1;
      checks++; if (o_req_stall !== 2'b10) begin errors++; $display("FAIL midrst_rr_reset: got %b expected 10", o_req_stall); end
      step();
      checks++;
      if ({o_con_stb, o_con_data, o_grant} !== {1'b1, 32'h66, 3'd0}) begin
         errors++; $display("FAIL midrst_next: got stb=%b data=%h grant=%0d expected 1 00000066 0", o_con_stb, o_con_data, o_grant);
      end
      step();
      step();
      checks++; if (o_req_ack !== 2'b01)   begin errors++; $display("FAIL midrst_next_ack: got %b expected 01", o_req_ack); end
   endtask

   initial begin
      i_reset     = 1'b1;
      i_req_stb   = '0;
      i_req_data  = '0;
      i_con_ack   = 1'b0;
      i_con_stall = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_line_lock();
      test_lock_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/console_arbiter.md
# console_arbiter

Shares the single console sink between up to 8 bus requesters, for example CPU core, debug stub and DMA trace. Round-robin arbitration, one outstanding transfer at a time. Optional line locking so output lines from different requesters never interleave. Sits between the requester-side pipelined Wishbone-style strobes and the console's `i_wb_stb`/`i_wb_data`/`o_wb_ack`/`o_wb_stall` port.

## Interface
Parameters:
- `NREQ`, default 2, number of requesters; legal range 2..8.
- `LOCK_TIMEOUT`, default 255, idle cycles after which a line lock is dropped; must be ≥1.

Ports:
- `i_clk`  in  1  single clock; all logic on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_req_stb`  in  NREQ  per-requester strobe; bit i is requester i.
- `i_req_data`  in  NREQ*32  requester i data at `[32*i+31:32*i]`; only `[7:0]` is meaningful to the console.
- `o_req_ack`  out  NREQ  one-cycle ack to the granted requester.
- `o_req_stall`  out  NREQ  combinational; low only for the requester whose strobe is accepted this cycle.
- `o_con_stb`  out  1  strobe to console.
- `o_con_data`  out  32  data to console, registered.
- `i_con_ack`  in  1  console ack.
- `i_con_stall`  in  1  console stall.
- `o_grant`  out  3  index of current or last granted requester.
- `o_busy`  out  1  high in every state other than IDLE.

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: `o_con_stb` high.
  - WAIT_ACK: waiting for the console ack.
- IDLE:
  - The winner w is the first requester with `i_req_stb` set, searching from `rr_ptr` upward modulo NREQ.
  - `o_req_stall[w]`=0; all other stall bits are 1.
  - On the clock edge: `o_con_data`<=data of w, `o_con_stb`<=1, `o_grant`<=w, `rr_ptr`<=(w+1)%NREQ, then go to ISSUE.
  - With no strobe asserted, all stall bits are 0 and the block stays in IDLE.
- ISSUE:
  - `o_con_stb` and `o_con_data` are held stable while `i_con_stall`=1.
  - On the first cycle with `i_con_stall`=0: `o_con_stb`<=0, go to WAIT_ACK.
  - All `o_req_stall` bits are 1.
- WAIT_ACK:
  - On `i_con_ack`=1: `o_req_ack[o_grant]`<=1 for exactly one cycle, go to IDLE.
  - An ack arriving in ISSUE is ignored; the console acks one cycle after acceptance.
  - All `o_req_stall` bits are 1.
- A requester whose strobe is not accepted keeps its strobe and data asserted. The arbiter never drops or duplicates a byte.
- Simultaneous strobes: only one winner per IDLE cycle; the others stay stalled.

## Timing
- Reset values:
  - state=IDLE, `o_con_stb`=0, `o_con_data`=0, `o_req_ack`=0, `o_grant`=0, `o_busy`=0.
  - `rr_ptr`=0, so requester 0 has the highest priority first.
  - Lock cleared, timeout counter 0.
- Reset mid-transfer: the pending transfer is abandoned, no `o_req_ack` is emitted, and the block returns to IDLE on the next edge.
- Latency with the console not stalling, request accepted in cycle T:
  - `o_con_stb` high in T+1.
  - Console ack in T+2.
  - `o_req_ack` in T+3.
  - The next acceptance is possible in T+3.
  - Throughput is one byte per 3 cycles.
- Each cycle of console stall adds exactly one cycle to this latency.
- `o_busy`=1 exactly when state≠IDLE.

## Configuration
Controlled by `CONSOLE_ARB_LINE_LOCK_EN`.
- Defined:
  - Accepting a byte whose `[7:0]`≠8'h0A from requester w sets lock, `lock_owner`=w.
  - While the lock is set, IDLE considers only `lock_owner`; other requesters are stalled.
  - The lock clears when the owner's accepted byte is 8'h0A, effective for the next arbitration.
  - The lock also clears after `LOCK_TIMEOUT` consecutive IDLE cycles without the owner's strobe.
  - The timeout counter resets on every owner acceptance and saturates at `LOCK_TIMEOUT`.
  - `rr_ptr` still advances normally.
- Undefined: pure round robin per byte; no lock registers or counter are synthesized.

## Test plan
- Requester 0 strobes 0x41, console never stalls, accepted in T → `o_con_stb`=1 with `o_con_data`=0x41 in T+1; `o_req_ack`=2'b01 in T+3.
- Both requesters strobe continuously with newline bytes, from reset → console order req0, req1, req0, req1; stalled requester's data reaches the console unchanged.
- `i_con_stall` held high 4 cycles during ISSUE → `o_con_stb`/`o_con_data` stable for 4 cycles; `o_req_ack` at T+7.
- `CONSOLE_ARB_LINE_LOCK_EN` set: req0 sends "A","B",0x0A while req1 strobes 0x58 throughout → console sees 0x41, 0x42, 0x0A, 0x58.
- Lock set, `LOCK_TIMEOUT`=8: req0 sends 0x41 then idles, req1 waiting → req1 accepted on the 9th IDLE cycle after req0's ack, not earlier.
- `i_reset` pulsed during WAIT_ACK → `o_con_stb`=0, `o_req_ack`=0, state IDLE; the next strobe after reset is accepted normally.
